// File: rtl/vrf_read_sequencer.sv
// VRF read-port sequencer: issues a burst of reads through the 2-cycle VRF pipeline and streams
// the returned words to the lane ALU through a credit-protected FWFT buffer.
module vrf_read_sequencer #(
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned MEM_WIDTH  = 32,
  parameter int unsigned VL_W       = 11,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW        = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic [AW-1:0]        base_addr_i,
  input  logic [VL_W-1:0]      vl_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [AW-1:0]        raddr_o,
  output logic                 ren_o,
  output logic                 oreg_ren_o,
  input  logic [MEM_WIDTH-1:0] rdata_i,
  output logic [MEM_WIDTH-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [VL_W-1:0]      rem_issue_q, rem_issue_d;
  logic [VL_W-1:0]      rem_out_q, rem_out_d;
  logic                 done_q, done_d;
  logic                 v1_q, v2_q;
  logic [MEM_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0]        wptr_q, rptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        occupancy;
  logic                 push, pop;

  // Credits count words already buffered plus reads still travelling through the VRF pipeline.
  assign occupancy = count_q + CW'(v1_q) + CW'(v2_q);
  assign push      = v2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i && (vl_i != '0)) state_d = StIssue;
      StIssue: if (ren_o && (rem_issue_q == VL_W'(1))) state_d = StDrain;
      StDrain: if (pop && last_o) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o  = (state_q != StIdle);
    ren_o   = (state_q == StIssue) && (occupancy < CW'(FIFO_DEPTH));
    valid_o = (count_q != '0);
    last_o  = valid_o && (rem_out_q == VL_W'(1));
    pop     = valid_o && ready_i;
  end

  always_comb begin
    addr_d      = addr_q;
    rem_issue_d = rem_issue_q;
    rem_out_d   = rem_out_q;
    done_d      = 1'b0;
    if ((state_q == StIdle) && start_i) begin
      if (vl_i != '0) begin
        addr_d      = base_addr_i;
        rem_issue_d = vl_i;
        rem_out_d   = vl_i;
      end else begin
        done_d = 1'b1;
      end
    end
    if (ren_o) begin
      addr_d      = (addr_q == AW'(MEM_DEPTH - 1)) ? '0 : addr_q + AW'(1);
      rem_issue_d = rem_issue_q - VL_W'(1);
    end
    if (pop) begin
      rem_out_d = rem_out_q - VL_W'(1);
      if (last_o) done_d = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q      <= '0;
      rem_issue_q <= '0;
      rem_out_q   <= '0;
      done_q      <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      addr_q      <= addr_d;
      rem_issue_q <= rem_issue_d;
      rem_out_q   <= rem_out_d;
      done_q      <= done_d;
      v1_q        <= ren_o;
      v2_q        <= v1_q;
      count_q     <= count_d;
      if (push) begin
        fifo_q[wptr_q] <= rdata_i;
        wptr_q         <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
    end
  end

  assign done_o     = done_q;
  assign raddr_o    = addr_q;
  assign oreg_ren_o = v1_q;
  assign data_o     = fifo_q[rptr_q];

endmodule

// File: tb/tb_vrf_read_sequencer.sv
// Randomized bench for vrf_read_sequencer: a VRF latency model feeds the DUT and a word-level
// scoreboard derived from each burst's base/length checks the delivered stream.
module tb_vrf_read_sequencer;

  localparam int unsigned MEM_DEPTH  = 1024;
  localparam int unsigned MEM_WIDTH  = 32;
  localparam int unsigned VL_W       = 11;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned AW         = $clog2(MEM_DEPTH);

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 start_i;
  logic [AW-1:0]        base_addr_i;
  logic [VL_W-1:0]      vl_i;
  logic                 busy_o, done_o, ren_o, oreg_ren_o, valid_o, ready_i, last_o;
  logic [AW-1:0]        raddr_o;
  logic [MEM_WIDTH-1:0] rdata_i, data_o;
  logic [MEM_WIDTH-1:0] arr_q;

  vrf_read_sequencer #(
    .MEM_DEPTH (MEM_DEPTH),
    .MEM_WIDTH (MEM_WIDTH),
    .VL_W      (VL_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .vl_i       (vl_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .raddr_o    (raddr_o),
    .ren_o      (ren_o),
    .oreg_ren_o (oreg_ren_o),
    .rdata_i    (rdata_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .last_o     (last_o)
  );

  always #5 clk = ~clk;

  // VRF: array stage on ren_o, output register on oreg_ren_o; word content tags its address.
  always @(posedge clk) begin
    if (ren_o) arr_q <= 32'hA500_0000 | 32'(raddr_o);
    if (oreg_ren_o) rdata_i <= arr_q;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [MEM_WIDTH-1:0] exp_q[$];
  int cyc = 0, issued = 0, delivered = 0, done_cnt = 0;
  int mon_base = 0, mon_vl = 0;
  int first_ren_cyc = 0, last_ren_cyc = 0, first_valid_cyc = 0;
  bit seen_valid = 0, exp_done = 0, prev_ren = 0, prev_stall = 0;
  logic [MEM_WIDTH-1:0] prev_data;

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        exp_q.delete();
        issued = 0; delivered = 0; mon_vl = 0;
        exp_done = 0; prev_ren = 0; prev_stall = 0;
      end else begin
        check_eq("done", done_o, exp_done);
        if (done_o) begin
          done_cnt++;
          check_eq("busy_at_done", busy_o, 0);
        end
        exp_done = 0;
        check_eq("oreg_ren", oreg_ren_o, prev_ren);
        prev_ren = ren_o;
        if (ren_o) begin
          if (issued == 0) first_ren_cyc = cyc;
          last_ren_cyc = cyc;
          check_eq("ren_in_burst", busy_o && (issued < mon_vl), 1);
          check_eq("raddr", raddr_o, (mon_base + issued) % MEM_DEPTH);
          issued++;
          check_eq("credit", (issued - delivered) <= int'(FIFO_DEPTH), 1);
        end
        if (prev_stall && valid_o) check_eq("stall_hold", data_o, prev_data);
        if (valid_o) begin
          if (!seen_valid) begin
            seen_valid      = 1;
            first_valid_cyc = cyc;
          end
          if (exp_q.size() == 0) begin
            check_eq("extra_word_valid", valid_o, 0);
          end else begin
            check_eq("last", last_o, exp_q.size() == 1);
            if (ready_i) begin
              check_eq("data", data_o, exp_q.pop_front());
              delivered++;
              if (exp_q.size() == 0) exp_done = 1;
            end
          end
        end
        prev_stall = valid_o && !ready_i;
        prev_data  = data_o;
        if (start_i && !busy_o) begin
          if (vl_i == '0) begin
            exp_done = 1;
          end else begin
            mon_base = int'(base_addr_i);
            mon_vl   = int'(vl_i);
            issued = 0; delivered = 0; seen_valid = 0;
            for (int i = 0; i < mon_vl; i++)
              exp_q.push_back(32'hA500_0000 | 32'((mon_base + i) % MEM_DEPTH));
          end
        end
      end
    end
  end

  task automatic start_burst(input int base, input int vl);
    @(posedge clk); #1;
    start_i     = 1'b1;
    base_addr_i = AW'(base);
    vl_i        = VL_W'(vl);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int max_cyc);
    for (int i = 0; i < max_cyc && done_cnt == d0; i++) @(negedge clk);
    check_eq("done_seen", done_cnt != d0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_done"}, done_o, 0);
    check_eq({tag, "_ren"}, ren_o, 0);
    check_eq({tag, "_oreg"}, oreg_ren_o, 0);
    check_eq({tag, "_valid"}, valid_o, 0);
    check_eq({tag, "_last"}, last_o, 0);
    check_eq({tag, "_raddr"}, raddr_o, 0);
    check_eq({tag, "_data"}, data_o, 0);
  endtask

  int d0, lat;

  initial begin
    rstn = 1'b0; start_i = 1'b0; base_addr_i = '0; vl_i = '0; ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;

    // Basic burst with the consumer always ready.
    ready_i = 1'b1;
    d0 = done_cnt;
    start_burst(32'h010, 4);
    wait_done(d0, 100);
    check_eq("basic_delivered", delivered, 4);
    check_eq("basic_ren_span", last_ren_cyc - first_ren_cyc, 3);
    lat = first_valid_cyc - first_ren_cyc;
    check_eq("basic_valid_latency", (lat >= 2) && (lat <= 3), 1);

    // Address wrap at the top of the VRF.
    d0 = done_cnt;
    start_burst(1022, 4);
    wait_done(d0, 100);
    check_eq("wrap_delivered", delivered, 4);

    // Consumer stalled for 20 cycles: issue must stop at the buffer depth.
    ready_i = 1'b0;
    d0 = done_cnt;
    start_burst(32'h040, 10);
    repeat (20) @(negedge clk);
    check_eq("bp_issued", issued, FIFO_DEPTH);
    check_eq("bp_valid", valid_o, 1);
    @(posedge clk); #1;
    ready_i = 1'b1;
    wait_done(d0, 200);
    check_eq("bp_delivered", delivered, 10);

    // Long burst under random backpressure.
    d0 = done_cnt;
    start_burst(int'($urandom_range(0, MEM_DEPTH - 1)), 64);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ready_i = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rand_done_count", done_cnt - d0, 1);
    check_eq("rand_delivered", delivered, 64);
    check_eq("rand_queue_empty", exp_q.size(), 0);

    // Zero-length request completes without touching the VRF.
    d0 = done_cnt;
    start_burst(5, 0);
    repeat (4) begin
      @(negedge clk);
      check_eq("vl0_busy", busy_o, 0);
      check_eq("vl0_ren", ren_o, 0);
    end
    check_eq("vl0_done_count", done_cnt - d0, 1);

    // Reset in the middle of a burst, then a fresh short burst.
    d0 = done_cnt;
    start_burst(32'h200, 8);
    for (int i = 0; i < 50 && issued < 3; i++) @(negedge clk);
    check_eq("mid_issued", issued >= 3, 1);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    rstn = 1'b1;
    d0 = done_cnt;
    start_burst(32'h100, 2);
    wait_done(d0, 100);
    repeat (6) @(negedge clk);
    check_eq("post_rst_delivered", delivered, 2);
    check_eq("post_rst_queue_empty", exp_q.size(), 0);
    check_eq("post_rst_done_count", done_cnt - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
